// File: rtl/sync_reg_feeder_pkg.sv
// Shared types and sizing helpers for the register-synchroniser feeder.
package sync_feeder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PEND = 2'd1,
      GAP  = 2'd2
   } feederState_t;

   // Width needed to hold the holdoff count; never narrower than one bit.
   function automatic int gapCntW(input int minGap);
      return (minGap < 1) ? 1 : $clog2(minGap + 1);
   endfunction

endpackage

// File: rtl/sync_reg_feeder_if.sv
// Update-side and synchroniser-side signals of the feeder, bundled with modports.
interface sync_reg_feeder_if #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
);
   logic             upd_valid;
   logic [WIDTH-1:0] upd_data;
   logic             sRDY;
   logic             sEN;
   logic [WIDTH-1:0] sD_IN;
   logic             pending;
   logic [CNT_W-1:0] drop_cnt;

   modport master (
      output upd_valid, upd_data, sRDY,
      input  sEN, sD_IN, pending, drop_cnt
   );

   modport slave (
      input  upd_valid, upd_data, sRDY,
      output sEN, sD_IN, pending, drop_cnt
   );
endinterface

// File: rtl/sync_reg_feeder_sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         sCLK,
   input  logic         sRST,
   input  logic         inc,
   output logic [W-1:0] value
);

   // NOTE: registers are written with <= so every flop samples pre-edge values.
   always_ff @(posedge sCLK) begin
      if (sRST) begin
         value <= '0;
      end else if (inc && (value != '1)) begin
         value <= value + W'(1);
      end
   end

endmodule

// File: rtl/sync_reg_feeder.sv
// Holds the latest update and hands it to a register synchroniser via sEN/sRDY,
// with optional duplicate suppression, post-send holdoff and overwrite counting.
module sync_reg_feeder
   import sync_feeder_pkg::*;
#(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] INIT         = '0,
   parameter int               MIN_GAP      = 0,
   parameter bit               SUPPRESS_DUP = 1'b1,
   parameter int               CNT_W        = 16
) (
   input logic               sCLK,
   input logic               sRST,
   sync_reg_feeder_if.slave  bus
);

   localparam int            GW       = gapCntW(MIN_GAP);
   localparam logic [GW-1:0] GAP_LOAD = GW'(MIN_GAP);
   localparam logic [GW-1:0] GAP_ONE  = GW'(1);

   feederState_t     state, stateNext;
   logic [GW-1:0]    gapCnt, gapCntNext;
   logic [WIDTH-1:0] holdQ, lastSent, dupRef;
   logic             pendingQ, pendingNext;
   logic             sendNow, accept, dropInc;
   logic [CNT_W-1:0] dropCnt;

   assign sendNow = pendingQ && bus.sRDY && (state != GAP);

   // A value leaving this cycle already counts as last-sent for the duplicate test.
   assign dupRef      = sendNow ? holdQ : lastSent;
   assign accept      = bus.upd_valid && !(SUPPRESS_DUP && (bus.upd_data == dupRef));
   assign dropInc     = accept && pendingQ && !sendNow;
   assign pendingNext = accept || (pendingQ && !sendNow);

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      stateNext  = state;
      gapCntNext = gapCnt;
      case (state)
         GAP: begin
            if (gapCnt <= GAP_ONE) begin
               stateNext  = pendingNext ? PEND : IDLE;
               gapCntNext = '0;
            end else begin
               gapCntNext = gapCnt - GAP_ONE;
            end
         end
         default: begin
            if (sendNow && (MIN_GAP > 0)) begin
               stateNext  = GAP;
               gapCntNext = GAP_LOAD;
            end else begin
               stateNext  = pendingNext ? PEND : IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge sCLK) begin
      if (sRST) begin
         state  <= IDLE;
         gapCnt <= '0;
      end else begin
         state  <= stateNext;
         gapCnt <= gapCntNext;
      end
   end

   // NOTE: the data registers are reset because sD_IN must read INIT out of reset.
   always_ff @(posedge sCLK) begin
      if (sRST) begin
         holdQ    <= INIT;
         lastSent <= INIT;
         pendingQ <= 1'b0;
      end else begin
         if (accept)  holdQ    <= bus.upd_data;
         if (sendNow) lastSent <= holdQ;
         pendingQ <= pendingNext;
      end
   end

   sat_counter #(.W(CNT_W)) u_dropCnt (
      .sCLK  (sCLK),
      .sRST  (sRST),
      .inc   (dropInc),
      .value (dropCnt)
   );

   assign bus.sEN      = sendNow;
   assign bus.sD_IN    = holdQ;
   assign bus.pending  = pendingQ;
   assign bus.drop_cnt = dropCnt;

endmodule

// File: tb/tb_sync_reg_feeder.sv
// Directed bench: four feeder configurations driven in sequence from one initial block.
module tb_sync_reg_feeder;
   import sync_feeder_pkg::*;

   logic sCLK = 1'b0;
   logic sRST;
   int   total   = 0;
   int   passCnt = 0;
   int   failCnt = 0;

   always #5 sCLK = ~sCLK;

   sync_reg_feeder_if #(.WIDTH(8), .CNT_W(16)) ifA ();
   sync_reg_feeder_if #(.WIDTH(8), .CNT_W(16)) ifB ();
   sync_reg_feeder_if #(.WIDTH(8), .CNT_W(16)) ifC ();
   sync_reg_feeder_if #(.WIDTH(8), .CNT_W(2))  ifD ();

   sync_reg_feeder #(.WIDTH(8), .INIT(8'h5A), .MIN_GAP(0), .SUPPRESS_DUP(1'b1), .CNT_W(16))
      dutA (.sCLK(sCLK), .sRST(sRST), .bus(ifA));
   sync_reg_feeder #(.WIDTH(8), .INIT(8'h5A), .MIN_GAP(0), .SUPPRESS_DUP(1'b0), .CNT_W(16))
      dutB (.sCLK(sCLK), .sRST(sRST), .bus(ifB));
   sync_reg_feeder #(.WIDTH(8), .INIT(8'h00), .MIN_GAP(3), .SUPPRESS_DUP(1'b1), .CNT_W(16))
      dutC (.sCLK(sCLK), .sRST(sRST), .bus(ifC));
   sync_reg_feeder #(.WIDTH(8), .INIT(8'h00), .MIN_GAP(0), .SUPPRESS_DUP(1'b1), .CNT_W(2))
      dutD (.sCLK(sCLK), .sRST(sRST), .bus(ifD));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passCnt++;
      else begin
         failCnt++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge sCLK);
      #1;
   endtask

   task automatic driveA(input logic v, input logic [7:0] d, input logic r);
      ifA.upd_valid = v;
      ifA.upd_data  = d;
      ifA.sRDY      = r;
   endtask

   logic [9:0] expEnC;
   int         expDropD [6];

   initial begin
      expEnC   = 10'b10_0010_0010;
      expDropD = '{0, 1, 2, 3, 3, 3};
      sRST = 1'b1;
      driveA(1'b0, 8'h00, 1'b0);
      ifB.upd_valid = 1'b0; ifB.upd_data = 8'h00; ifB.sRDY = 1'b0;
      ifC.upd_valid = 1'b0; ifC.upd_data = 8'h00; ifC.sRDY = 1'b0;
      ifD.upd_valid = 1'b0; ifD.upd_data = 8'h00; ifD.sRDY = 1'b0;
      tick;
      tick;

      // Updates offered while in reset must be ignored.
      driveA(1'b1, 8'h33, 1'b1);
      tick;
      check("rst_pending", 32'(ifA.pending), 0);
      check("rst_sEN", 32'(ifA.sEN), 0);
      check("rst_sD_IN", 32'(ifA.sD_IN), 'h5A);
      check("rst_drop", 32'(ifA.drop_cnt), 0);

      // First cycle after release accepts; sEN follows one cycle later.
      sRST = 1'b0;
      driveA(1'b1, 8'h11, 1'b1);
      ifB.upd_valid = 1'b1; ifB.upd_data = 8'h11; ifB.sRDY = 1'b1;
      tick;
      driveA(1'b0, 8'h00, 1'b1);
      ifB.upd_valid = 1'b0;
      #1;
      check("lat_sEN", 32'(ifA.sEN), 1);
      check("lat_sD_IN", 32'(ifA.sD_IN), 'h11);
      check("lat_pending", 32'(ifA.pending), 1);
      tick;
      check("sent_pending", 32'(ifA.pending), 0);
      check("sent_sEN", 32'(ifA.sEN), 0);
      check("B_sent_sEN", 32'(ifB.sEN), 0);

      // Re-offer the last-sent value: A suppresses, B sends it again.
      driveA(1'b1, 8'h11, 1'b1);
      ifB.upd_valid = 1'b1; ifB.upd_data = 8'h11;
      tick;
      driveA(1'b0, 8'h00, 1'b1);
      ifB.upd_valid = 1'b0;
      #1;
      check("dup_pending", 32'(ifA.pending), 0);
      check("dup_sEN", 32'(ifA.sEN), 0);
      check("dup_drop", 32'(ifA.drop_cnt), 0);
      check("B_dup_pending", 32'(ifB.pending), 1);
      check("B_dup_sEN", 32'(ifB.sEN), 1);
      check("B_dup_sD_IN", 32'(ifB.sD_IN), 'h11);
      tick;
      check("B_dup_done", 32'(ifB.pending), 0);

      // Value equal to the one leaving this cycle counts as a duplicate.
      driveA(1'b1, 8'h22, 1'b1);
      tick;
      #1;
      check("samecyc_sEN", 32'(ifA.sEN), 1);
      check("samecyc_sD_IN", 32'(ifA.sD_IN), 'h22);
      tick;
      driveA(1'b0, 8'h00, 1'b1);
      #1;
      check("samecyc_pending", 32'(ifA.pending), 0);

      // Send and capture in the same cycle: no drop, new value pending.
      driveA(1'b1, 8'h33, 1'b1);
      tick;
      driveA(1'b1, 8'h44, 1'b1);
      #1;
      check("overlap_sD_IN_old", 32'(ifA.sD_IN), 'h33);
      tick;
      driveA(1'b0, 8'h00, 1'b1);
      #1;
      check("overlap_pending", 32'(ifA.pending), 1);
      check("overlap_sD_IN_new", 32'(ifA.sD_IN), 'h44);
      check("overlap_drop", 32'(ifA.drop_cnt), 0);
      check("overlap_sEN", 32'(ifA.sEN), 1);
      tick;
      check("overlap_done", 32'(ifA.pending), 0);

      // Three updates with sRDY low: two overwrites, then one transfer of the last.
      driveA(1'b1, 8'h0A, 1'b0);
      tick;
      driveA(1'b1, 8'h0B, 1'b0);
      tick;
      check("ovw_drop1", 32'(ifA.drop_cnt), 1);
      driveA(1'b1, 8'h0C, 1'b0);
      tick;
      driveA(1'b0, 8'h00, 1'b0);
      #1;
      check("ovw_drop2", 32'(ifA.drop_cnt), 2);
      check("ovw_sEN_blocked", 32'(ifA.sEN), 0);
      check("ovw_sD_IN", 32'(ifA.sD_IN), 'h0C);
      driveA(1'b0, 8'h00, 1'b1);
      #1;
      check("ovw_sEN", 32'(ifA.sEN), 1);
      tick;
      check("ovw_done_sEN", 32'(ifA.sEN), 0);
      check("ovw_done_drop", 32'(ifA.drop_cnt), 2);

      // Reset with a value pending discards it.
      driveA(1'b1, 8'h77, 1'b0);
      tick;
      driveA(1'b0, 8'h00, 1'b0);
      check("prerst_pending", 32'(ifA.pending), 1);
      sRST = 1'b1;
      driveA(1'b0, 8'h00, 1'b1);
      tick;
      #1;
      check("midrst_pending", 32'(ifA.pending), 0);
      check("midrst_sEN", 32'(ifA.sEN), 0);
      check("midrst_sD_IN", 32'(ifA.sD_IN), 'h5A);
      check("midrst_drop", 32'(ifA.drop_cnt), 0);
      sRST = 1'b0;
      tick;
      tick;
      check("postrst_sEN", 32'(ifA.sEN), 0);
      driveA(1'b1, 8'h5A, 1'b1);
      tick;
      driveA(1'b0, 8'h00, 1'b1);
      #1;
      check("init_dup_pending", 32'(ifA.pending), 0);
      driveA(1'b1, 8'h66, 1'b1);
      tick;
      driveA(1'b0, 8'h00, 1'b1);
      #1;
      check("postrst_send", 32'(ifA.sEN), 1);
      check("postrst_sD_IN", 32'(ifA.sD_IN), 'h66);
      tick;

      // Holdoff of 3: with an update every cycle, sends land in cycles 1, 5, 9.
      ifC.sRDY = 1'b1;
      for (int k = 0; k < 10; k++) begin
         ifC.upd_valid = 1'b1;
         ifC.upd_data  = 8'(k + 1);
         #1;
         check($sformatf("gap_sEN_c%0d", k), 32'(ifC.sEN), 32'(expEnC[k]));
         if (expEnC[k]) check($sformatf("gap_sD_IN_c%0d", k), 32'(ifC.sD_IN), 32'(k));
         tick;
      end
      ifC.upd_valid = 1'b0;
      #1;
      check("gap_drop", 32'(ifC.drop_cnt), 6);
      for (int j = 0; j < 3; j++) begin
         #1;
         check($sformatf("gap_hold_%0d", j), 32'(ifC.sEN), 0);
         tick;
      end
      #1;
      check("gap_exit_sEN", 32'(ifC.sEN), 1);
      check("gap_exit_sD_IN", 32'(ifC.sD_IN), 'h0A);

      // Two-bit drop counter: five overwrites saturate at 3.
      for (int k = 0; k < 6; k++) begin
         ifD.upd_valid = 1'b1;
         ifD.upd_data  = 8'(k + 1);
         tick;
         check($sformatf("sat_drop_%0d", k), 32'(ifD.drop_cnt), 32'(expDropD[k]));
      end
      ifD.upd_valid = 1'b0;
      check("sat_sD_IN", 32'(ifD.sD_IN), 'h06);
      check("sat_pending", 32'(ifD.pending), 1);

      $display("%0d/%0d checks passed", passCnt, total);
      $finish;
   end

endmodule
